// File: rtl/pci_pa_count_ctrl_if.sv
// ---------------------------------------------------------------------------
// pci_pa_count_ctrl_if
// Register-side command/status bundle for the PCIe performance-analysis
// measurement-window sequencer.
//
// Signals
//   cmd_start, cmd_stop, cmd_clear : single-cycle command pulses
//   start_clear                    : sampled with cmd_start, 1 = zero counters first
//   window_cycles[CNT_WIDTH]       : window length, 0 = free-run until cmd_stop
//   pa_count_reset/pa_count_enable : drive the counter block
//   busy, done, elapsed_cycles     : status back to the register file
//   state[2]                       : IDLE=0, CLEAR=1, RUN=2, DRAIN=3
//   pa_irq, irq_ack                : completion interrupt (PA_COUNT_CTRL_IRQ_EN only)
//
// Modports: master = register file side, slave = sequencer.
// ---------------------------------------------------------------------------
interface pci_pa_count_ctrl_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 cmd_start;
  logic                 cmd_stop;
  logic                 cmd_clear;
  logic                 start_clear;
  logic [CNT_WIDTH-1:0] window_cycles;
  logic                 pa_count_reset;
  logic                 pa_count_enable;
  logic                 busy;
  logic                 done;
  logic [CNT_WIDTH-1:0] elapsed_cycles;
  logic [1:0]           state;
`ifdef PA_COUNT_CTRL_IRQ_EN
  logic                 pa_irq;
  logic                 irq_ack;

  modport master (
    output cmd_start, cmd_stop, cmd_clear, start_clear, window_cycles, irq_ack,
    input  pa_count_reset, pa_count_enable, busy, done, elapsed_cycles, state, pa_irq
  );
  modport slave (
    input  cmd_start, cmd_stop, cmd_clear, start_clear, window_cycles, irq_ack,
    output pa_count_reset, pa_count_enable, busy, done, elapsed_cycles, state, pa_irq
  );
`else
  modport master (
    output cmd_start, cmd_stop, cmd_clear, start_clear, window_cycles,
    input  pa_count_reset, pa_count_enable, busy, done, elapsed_cycles, state
  );
  modport slave (
    input  cmd_start, cmd_stop, cmd_clear, start_clear, window_cycles,
    output pa_count_reset, pa_count_enable, busy, done, elapsed_cycles, state
  );
`endif
endinterface

// File: rtl/pci_pa_count_ctrl.sv
// ---------------------------------------------------------------------------
// pci_pa_count_ctrl
// Measurement-window sequencer for the PCIe completer-side performance
// analysis counters. Turns start/stop/clear commands into pa_count_reset and
// pa_count_enable, with enable delayed by PIPE_LAT so it lines up with the
// counter block's monitor pipeline: the counters see exactly the bus beats
// that occurred during RUN.
//
// Ports
//   user_clk : clock
//   reset_n  : asynchronous active-low reset (returns to IDLE, enable drops)
//   bus      : pci_pa_count_ctrl_if.slave command/status bundle
//
// Parameters
//   PIPE_LAT  : monitor pipeline depth, also DRAIN length (>= 1)
//   CNT_WIDTH : width of window_cycles / elapsed_cycles
//
// Optional build macro
//   PA_COUNT_CTRL_IRQ_EN : adds pa_irq (set with done, held until irq_ack;
//                          a coincident set wins over the ack)
// ---------------------------------------------------------------------------
module pci_pa_count_ctrl #(
  parameter int PIPE_LAT  = 2,
  parameter int CNT_WIDTH = 32
) (
  input  logic                  user_clk,
  input  logic                  reset_n,
  pci_pa_count_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int            DW         = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LAT - 1);

  // Saturating increment: elapsed_cycles sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) return v;
    return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_t               state_q, state_d;
  logic                 ret_run_q, ret_run_d;
  logic                 leave_idle;
  logic                 drain_last;
  logic [CNT_WIDTH-1:0] win_q;
  logic [CNT_WIDTH-1:0] elapsed_q;
  logic [CNT_WIDTH:0]   elapsed_inc;
  logic [DW-1:0]        drain_cnt_q;
  logic                 done_q;
  logic                 busy_q;
  logic                 cnt_reset_q;
  logic [PIPE_LAT-1:0]  run_p;

  // One extra bit so the window compare is exact even at elapsed = all-ones.
  assign elapsed_inc = {1'b0, elapsed_q} + {{CNT_WIDTH{1'b0}}, 1'b1};

  always_comb begin
    state_d    = state_q;
    ret_run_d  = ret_run_q;
    leave_idle = 1'b0;
    drain_last = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Start takes priority; start together with clear means start-with-clear.
        if (bus.cmd_start) begin
          state_d    = (bus.start_clear || bus.cmd_clear) ? CLEAR : RUN;
          ret_run_d  = 1'b1;
          leave_idle = 1'b1;
        end else if (bus.cmd_clear) begin
          state_d    = CLEAR;
          ret_run_d  = 1'b0;
          leave_idle = 1'b1;
        end
      end
      CLEAR: state_d = ret_run_q ? RUN : IDLE;
      RUN: begin
        if (bus.cmd_stop || ((win_q != '0) && (elapsed_inc == {1'b0, win_q})))
          state_d = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d    = IDLE;
          drain_last = 1'b1;
        end
      end
    endcase
  end

  // ---- stage boundary: control registers (state, status, counters) ----
  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ret_run_q   <= 1'b0;
      drain_cnt_q <= '0;
      elapsed_q   <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      cnt_reset_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_run_q   <= ret_run_d;
      drain_cnt_q <= (state_q == DRAIN) ? drain_cnt_q + DW'(1) : '0;
      if (leave_idle)            elapsed_q <= '0;
      else if (state_q == RUN)   elapsed_q <= sat_inc(elapsed_q);
      if (leave_idle)            done_q    <= 1'b0;
      else if (drain_last)       done_q    <= 1'b1;
      busy_q      <= (state_d != IDLE);
      cnt_reset_q <= (state_d == CLEAR);
    end
  end

  // Window length is captured once when leaving IDLE; mid-run changes are ignored.
  always_ff @(posedge user_clk) begin
    if (leave_idle) win_q <= bus.window_cycles;
  end

  // ---- stage boundary: run flag delay line, run_p[PIPE_LAT-1] is the enable ----
  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      run_p <= '0;
    end else begin
      run_p[0] <= (state_q == RUN);
      for (int i = 1; i < PIPE_LAT; i++) run_p[i] <= run_p[i-1];
    end
  end

`ifdef PA_COUNT_CTRL_IRQ_EN
  logic irq_q;

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n)         irq_q <= 1'b0;
    else if (drain_last)  irq_q <= 1'b1;
    else if (bus.irq_ack) irq_q <= 1'b0;
  end

  assign bus.pa_irq = irq_q;
`endif

  assign bus.pa_count_reset  = cnt_reset_q;
  assign bus.pa_count_enable = run_p[PIPE_LAT-1];
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.elapsed_cycles  = elapsed_q;
  assign bus.state           = state_q;

endmodule

// File: tb/tb_pci_pa_count_ctrl.sv
`timescale 1ns/1ps
module tb_pci_pa_count_ctrl;

  localparam int     PIPE_LAT  = 2;
  localparam int     CNT_WIDTH = 32;
  localparam longint NEVER     = 64'sh3fff_ffff_ffff_ffff;

  localparam int F_ST = 0, F_EN = 1, F_RST = 2, F_DONE = 3, F_ELA = 4, F_BUSY = 5, F_IRQ = 6;

  logic user_clk = 1'b0;
  logic reset_n  = 1'b0;

  pci_pa_count_ctrl_if #(.CNT_WIDTH(CNT_WIDTH)) bus();

  pci_pa_count_ctrl #(.PIPE_LAT(PIPE_LAT), .CNT_WIDTH(CNT_WIDTH)) dut (
    .user_clk (user_clk),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  always #5 user_clk = ~user_clk;

  int errors = 0;
  int checks = 0;
  longint cyc = 0;

  // Reference model: one measurement is described by its timeline
  // (clear cycle, first RUN cycle, last RUN cycle); every output at
  // cycle c follows from where c falls on that timeline.
  int                   m_mode = 0;   // 0 none since reset, 1 clear only, 2 measurement
  longint               m_clr  = -1;
  longint               m_rs   = 0;
  longint               m_re   = 0;
  logic [CNT_WIDTH-1:0] m_win  = '0;
  logic                 m_irq  = 1'b0;

  typedef struct { longint cyc; int what; longint val; } pin_t;
  pin_t pins[$];

  function automatic int exp_state(longint c);
    if (m_mode == 0) return 0;
    if (c == m_clr) return 1;
    if (m_mode == 2 && c >= m_rs && c <= m_re) return 2;
    if (m_mode == 2 && c > m_re && c <= m_re + PIPE_LAT) return 3;
    return 0;
  endfunction

  function automatic bit exp_en(longint c);
    return (m_mode == 2) && (c >= m_rs + PIPE_LAT) && (c <= m_re + PIPE_LAT);
  endfunction

  function automatic longint exp_ela(longint c);
    if (m_mode != 2 || c < m_rs) return 0;
    if (c <= m_re) return c - m_rs;
    return m_re - m_rs + 1;
  endfunction

  function automatic bit exp_done(longint c);
    return (m_mode == 2) && (c > m_re + PIPE_LAT);
  endfunction

  function automatic logic dut_irq();
`ifdef PA_COUNT_CTRL_IRQ_EN
    return bus.pa_irq;
`else
    return 1'b0;
`endif
  endfunction

  function automatic longint dut_field(int what);
    case (what)
      F_ST:    return longint'(bus.state);
      F_EN:    return longint'(bus.pa_count_enable);
      F_RST:   return longint'(bus.pa_count_reset);
      F_DONE:  return longint'(bus.done);
      F_ELA:   return longint'(bus.elapsed_cycles);
      F_BUSY:  return longint'(bus.busy);
      default: return longint'(dut_irq());
    endcase
  endfunction

  function automatic string fname(int what);
    case (what)
      F_ST:    return "state";
      F_EN:    return "enable";
      F_RST:   return "count_reset";
      F_DONE:  return "done";
      F_ELA:   return "elapsed";
      F_BUSY:  return "busy";
      default: return "irq";
    endcase
  endfunction

  // Model update on every active edge, from the inputs sampled at that edge.
  always @(posedge user_clk) begin
    if (!reset_n) begin
      m_mode = 0;
      m_clr  = -1;
      m_irq  = 1'b0;
    end else begin
      int s;
      s = exp_state(cyc);
      if (s == 0) begin
        if (bus.cmd_start) begin
          m_mode = 2;
          m_win  = bus.window_cycles;
          if (bus.start_clear || bus.cmd_clear) begin
            m_clr = cyc + 1;
            m_rs  = cyc + 2;
          end else begin
            m_clr = -1;
            m_rs  = cyc + 1;
          end
          m_re = (m_win != '0) ? m_rs + longint'(m_win) - 1 : NEVER;
        end else if (bus.cmd_clear) begin
          m_mode = 1;
          m_clr  = cyc + 1;
        end
      end else if (s == 2 && bus.cmd_stop && cyc < m_re) begin
        m_re = cyc;
      end
`ifdef PA_COUNT_CTRL_IRQ_EN
      if (m_mode == 2 && cyc == m_re + PIPE_LAT) m_irq = 1'b1;
      else if (bus.irq_ack)                      m_irq = 1'b0;
`endif
    end
    cyc = cyc + 1;
  end

  // Single compare process, sampling on the inactive edge.
  always @(negedge user_clk) begin
    if (!reset_n) begin
      checks++;
      if (bus.state !== 2'd0 || bus.pa_count_enable !== 1'b0 || bus.busy !== 1'b0 ||
          bus.done !== 1'b0 || bus.pa_count_reset !== 1'b0 || bus.elapsed_cycles !== '0 ||
          dut_irq() !== 1'b0) begin
        errors++;
        $display("FAIL reset_state cycle %0d: state=%0d en=%0b busy=%0b done=%0b rst=%0b ela=%0d irq=%0b, required all 0",
                 cyc, bus.state, bus.pa_count_enable, bus.busy, bus.done, bus.pa_count_reset,
                 bus.elapsed_cycles, dut_irq());
      end
    end else begin
      int     es;
      bit     een, edn;
      longint eela;
      logic   eirq;
      es   = exp_state(cyc);
      een  = exp_en(cyc);
      edn  = exp_done(cyc);
      eela = exp_ela(cyc);
      eirq = m_irq;
      checks++;
      if (bus.state !== 2'(es) || bus.pa_count_enable !== een || bus.pa_count_reset !== (es == 1) ||
          bus.busy !== (es != 0) || bus.done !== edn || {32'b0, bus.elapsed_cycles} !== 64'(eela) ||
          dut_irq() !== eirq) begin
        errors++;
        $display("FAIL model cycle %0d: got st=%0d en=%0b rst=%0b busy=%0b done=%0b ela=%0d irq=%0b; want st=%0d en=%0b rst=%0b busy=%0b done=%0b ela=%0d irq=%0b",
                 cyc, bus.state, bus.pa_count_enable, bus.pa_count_reset, bus.busy, bus.done,
                 bus.elapsed_cycles, dut_irq(), es, een, es == 1, es != 0, edn, eela, eirq);
      end
      checks++;
      if (bus.pa_count_reset === 1'b1 && bus.pa_count_enable === 1'b1) begin
        errors++;
        $display("FAIL overlap cycle %0d: reset=1 enable=1, required not both", cyc);
      end
      for (int i = pins.size() - 1; i >= 0; i--) begin
        if (pins[i].cyc == cyc) begin
          longint act;
          act = dut_field(pins[i].what);
          checks++;
          if (act !== pins[i].val) begin
            errors++;
            $display("FAIL pin_%s cycle %0d: got %0d, required %0d",
                     fname(pins[i].what), cyc, act, pins[i].val);
          end
          pins.delete(i);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge user_clk);
    #1;
  endtask

  task automatic pin(longint c, int what, longint val);
    pin_t p;
    p.cyc  = c;
    p.what = what;
    p.val  = val;
    pins.push_back(p);
  endtask

  task automatic set_ack(logic v);
`ifdef PA_COUNT_CTRL_IRQ_EN
    bus.irq_ack = v;
`else
    if (v) begin end
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint t0;
    bus.cmd_start     = 1'b0;
    bus.cmd_stop      = 1'b0;
    bus.cmd_clear     = 1'b0;
    bus.start_clear   = 1'b0;
    bus.window_cycles = '0;
    set_ack(1'b0);
    repeat (3) next_cycle();
    reset_n = 1'b1;
    repeat (2) next_cycle();

    // 1: window of 10, no clear
    t0 = cyc;
    bus.window_cycles = 10; bus.start_clear = 1'b0; bus.cmd_start = 1'b1;
    pin(t0+1, F_ST, 2);  pin(t0+10, F_ST, 2); pin(t0+11, F_ST, 3);
    pin(t0+2, F_EN, 0);  pin(t0+3, F_EN, 1);  pin(t0+12, F_EN, 1); pin(t0+13, F_EN, 0);
    pin(t0+13, F_ST, 0); pin(t0+13, F_DONE, 1); pin(t0+13, F_ELA, 10); pin(t0+12, F_BUSY, 1);
`ifdef PA_COUNT_CTRL_IRQ_EN
    pin(t0+12, F_IRQ, 0); pin(t0+13, F_IRQ, 1); pin(t0+15, F_IRQ, 1); pin(t0+16, F_IRQ, 0);
`endif
    next_cycle();
    bus.cmd_start = 1'b0;
    repeat (14) next_cycle();
    set_ack(1'b1);
    next_cycle();
    set_ack(1'b0);
    repeat (2) next_cycle();

    // 2: start with clear, window of 4; ack coincides with the done-set edge
    t0 = cyc;
    bus.window_cycles = 4; bus.start_clear = 1'b1; bus.cmd_start = 1'b1;
    pin(t0+1, F_RST, 1); pin(t0+1, F_ST, 1); pin(t0+2, F_RST, 0); pin(t0+2, F_ST, 2);
    pin(t0+5, F_ST, 2);  pin(t0+6, F_ST, 3); pin(t0+3, F_EN, 0);  pin(t0+4, F_EN, 1);
    pin(t0+7, F_EN, 1);  pin(t0+8, F_EN, 0); pin(t0+8, F_ST, 0);  pin(t0+8, F_ELA, 4);
    pin(t0+1, F_DONE, 0);
`ifdef PA_COUNT_CTRL_IRQ_EN
    pin(t0+8, F_IRQ, 1);
`endif
    next_cycle();
    bus.cmd_start = 1'b0; bus.start_clear = 1'b0;
    repeat (6) next_cycle();
    set_ack(1'b1);
    next_cycle();
    set_ack(1'b0);
    repeat (2) next_cycle();

    // 3: free-run, stopped 100 cycles after RUN entry
    t0 = cyc;
    bus.window_cycles = 0; bus.cmd_start = 1'b1;
    pin(t0+2, F_EN, 0);    pin(t0+3, F_EN, 1);   pin(t0+101, F_ST, 2); pin(t0+102, F_ST, 3);
    pin(t0+102, F_ELA, 101); pin(t0+103, F_EN, 1); pin(t0+104, F_EN, 0);
    pin(t0+103, F_DONE, 0); pin(t0+104, F_DONE, 1); pin(t0+104, F_ST, 0);
    next_cycle();
    bus.cmd_start = 1'b0;
    repeat (100) next_cycle();
    bus.cmd_stop = 1'b1;
    next_cycle();
    bus.cmd_stop = 1'b0;
    repeat (4) next_cycle();

    // 4: commands and window changes during RUN are ignored
    t0 = cyc;
    bus.window_cycles = 8; bus.cmd_start = 1'b1;
    pin(t0+4, F_RST, 0); pin(t0+4, F_ELA, 3); pin(t0+8, F_ST, 2); pin(t0+9, F_ST, 3);
    pin(t0+11, F_ST, 0); pin(t0+11, F_ELA, 8);
    next_cycle();
    bus.cmd_start = 1'b0;
    repeat (2) next_cycle();
    bus.cmd_start = 1'b1; bus.cmd_clear = 1'b1; bus.start_clear = 1'b1; bus.window_cycles = 3;
    next_cycle();
    bus.cmd_start = 1'b0; bus.cmd_clear = 1'b0; bus.start_clear = 1'b0; bus.window_cycles = 50;
    repeat (9) next_cycle();

    // 5: asynchronous reset in the middle of RUN, then a normal run
    t0 = cyc;
    bus.window_cycles = 20; bus.cmd_start = 1'b1;
    pin(t0+5, F_EN, 1);
    next_cycle();
    bus.cmd_start = 1'b0;
    repeat (5) next_cycle();
    #1 reset_n = 1'b0;
    @(posedge user_clk);
    @(posedge user_clk);
    #2 reset_n = 1'b1;
    next_cycle();
    t0 = cyc;
    bus.window_cycles = 3; bus.cmd_start = 1'b1;
    pin(t0+1, F_ST, 2); pin(t0+3, F_ST, 2); pin(t0+4, F_ST, 3);
    pin(t0+6, F_ST, 0); pin(t0+6, F_DONE, 1); pin(t0+6, F_ELA, 3);
    next_cycle();
    bus.cmd_start = 1'b0;
    repeat (8) next_cycle();

    // 6: randomized command traffic against the model
    for (int n = 0; n < 3000; n++) begin
      bus.cmd_start     = ($urandom_range(15) == 0);
      bus.cmd_stop      = ($urandom_range(19) == 0);
      bus.cmd_clear     = ($urandom_range(23) == 0);
      bus.start_clear   = 1'($urandom_range(1));
      bus.window_cycles = CNT_WIDTH'($urandom_range(12));
      set_ack($urandom_range(5) == 0);
      next_cycle();
    end
    bus.cmd_start = 1'b0; bus.cmd_stop = 1'b1; bus.cmd_clear = 1'b0; bus.start_clear = 1'b0;
    set_ack(1'b0);
    next_cycle();
    bus.cmd_stop = 1'b0;
    repeat (20) next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pci_pa_count_ctrl.md
Name: pci_pa_count_ctrl

Overview:
Measurement-window sequencer for the PCIe completer-side performance-analysis counter block. Accepts register-side start/stop/clear commands and drives that block's pa_count_reset and pa_count_enable inputs. pa_count_enable is delayed to match the counter block's 2-stage monitor pipeline, so exactly the bus cycles inside the window are counted. Reports busy/done status and elapsed window length to the register file.

Parameters:
PIPE_LAT, 2, cycles between a beat on the monitored bus and its arrival at the counter-increment stage; also the drain length.
CNT_WIDTH, 32, width of window_cycles and elapsed_cycles.

Ports:
user_clk  in  1  clock
reset_n  in  1  reset, asynchronous, active-low
cmd_start  in  1  single-cycle pulse: begin measurement
cmd_stop  in  1  single-cycle pulse: end measurement early / end free-run
cmd_clear  in  1  single-cycle pulse: zero counters
start_clear  in  1  sampled with cmd_start; 1 = zero counters before run
window_cycles  in  CNT_WIDTH  window length in cycles; 0 = free-run until cmd_stop
pa_count_reset  out  1  to counter block, 1 = clear
pa_count_enable  out  1  to counter block, 1 = count
busy  out  1  1 in any state except IDLE
done  out  1  sticky: last measurement completed
elapsed_cycles  out  CNT_WIDTH  RUN cycles of current/last window
state  out  2  IDLE=0, CLEAR=1, RUN=2, DRAIN=3

Behaviour:
- Reset values: state IDLE, pa_count_reset 0, pa_count_enable 0, busy 0, done 0, elapsed_cycles 0, run shift register all 0. All outputs are registered.
- IDLE:
  - cmd_start with start_clear=1 -> CLEAR, with return-to RUN latched.
  - cmd_start with start_clear=0 -> RUN.
  - cmd_clear alone -> CLEAR, then back to IDLE.
  - cmd_start and cmd_clear together -> treated as start with clear.
  - cmd_stop ignored.
  - Any start or clear zeroes done and elapsed_cycles.
- CLEAR: exactly 1 cycle; pa_count_reset=1 for that cycle only. Next state is RUN or IDLE as latched.
- RUN:
  - Internal run flag is 1.
  - elapsed_cycles increments every RUN cycle and saturates at all-ones (no wrap).
  - Exit to DRAIN at the end of the cycle where elapsed_cycles+1 == window_cycles (window_cycles != 0), or where cmd_stop=1; the stop cycle counts as a RUN cycle.
  - window_cycles is sampled once, on leaving IDLE; later changes are ignored.
  - cmd_start and cmd_clear are ignored.
- DRAIN: run flag 0. Stay exactly PIPE_LAT cycles, then -> IDLE and set done=1. Commands are ignored.
- pa_count_enable is the run flag delayed through a PIPE_LAT-deep shift register. If RUN spans cycles c..c+W-1, pa_count_enable is high on cycles c+PIPE_LAT..c+W-1+PIPE_LAT. The counters therefore see exactly the monitored-bus beats in cycles c..c+W-1.
- Latency: cmd_start at cycle t (no clear) gives RUN from t+1 and pa_count_enable from t+1+PIPE_LAT. With clear, add 1 cycle.
- pa_count_reset and pa_count_enable are never both 1.
- Async reset mid-measurement: immediate return to IDLE, enable drops at once, counters are not cleared by this block.

Optional Feature:
PA_COUNT_CTRL_IRQ_EN
- Defined: adds ports pa_irq (out, 1) and irq_ack (in, 1).
  - pa_irq is set on the same edge done is set, and held until irq_ack=1.
  - If a set and irq_ack coincide, set wins.
  - Reset value 0.
- Undefined: those ports are absent and done is the only completion indication.

Test Plan:
- Reset, then window_cycles=10, cmd_start with start_clear=0 at t0 -> RUN t0+1..t0+10; pa_count_enable high t0+3..t0+12; state IDLE at t0+13 with done=1, elapsed_cycles=10.
- start_clear=1, window_cycles=4 -> pa_count_reset high for one cycle at t0+1; RUN t0+2..t0+5; enable never overlaps reset.
- window_cycles=0, cmd_stop 100 cycles after RUN entry -> elapsed_cycles=101, enable high exactly 101 cycles, done=1 after 2 DRAIN cycles.
- cmd_start and cmd_clear during RUN, window_cycles changed mid-run -> no effect; window ends on the originally sampled value.
- Drop reset_n mid-RUN -> state 0, enable 0 and busy 0 immediately; a new start after release works normally.
- PA_COUNT_CTRL_IRQ_EN defined -> pa_irq rises with done, holds, clears on irq_ack. With irq_ack on the done-set cycle, pa_irq stays 1.
